// File: rtl/usb_proto_pkg.sv
// Shared USB host-protocol constants: framing words, decoder error codes and the
// command decoder state encoding.
package usb_proto_pkg;

    localparam logic [15:0] HDR_WORD   = 16'h55AA;

    // Device-to-host stream sync words live here so both directions share one source.
    localparam logic [15:0] SYNC_WORD0 = 16'h7CD2;
    localparam logic [15:0] SYNC_WORD1 = 16'h15D8;

    localparam logic [1:0]  ERR_LEN    = 2'd1;
    localparam logic [1:0]  ERR_CSUM   = 2'd2;
    localparam logic [1:0]  ERR_TMO    = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        COMMIT  = 3'd4
    } cmdState_e;

    // Register addresses wrap within the 8-bit register file.
    function automatic logic [7:0] wrapAddr(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// Simple dual-port payload buffer: synchronous write, registered read with enable.
// Storage is not reset; only the read register is.
module cmd_payload_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // The read register feeds the write-data output directly, so it must clear on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/usb_cmd_decoder.sv
// Frames host command packets from the EP2 word stream, checks the additive checksum
// and only then replays the buffered payload as register writes.
module usb_cmd_decoder #(
    parameter logic [15:0] HDR_WORD = usb_proto_pkg::HDR_WORD,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        usb_clk,
    input  logic        rst,
    input  logic [15:0] receive_data,
    input  logic        receive_data_en,
    output logic        reg_wr_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [1:0]  err_code,
    output logic        overrun,
    output logic        busy
);

    import usb_proto_pkg::*;

    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned GW        = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    cmdState_e     state_q;
    logic [7:0]    baseAddr_q;
    logic [7:0]    len_q;
    logic [7:0]    idx_q;
    logic [15:0]   sum_q;
    logic [GW-1:0] gap_q;
    logic          regWrEn_q;
    logic [7:0]    regAddr_q;
    logic          cmdOk_q;
    logic          cmdErr_q;
    logic [1:0]    errCode_q;
    logic          overrun_q;

    logic [15:0]   sumNext_d;
    logic          lastIdx_d;
    logic          gapHit_d;
    logic          bufWrEn_d;
    logic          bufRdEn_d;
    logic [15:0]   bufRdData;

    assign sumNext_d = sum_q + receive_data;
    assign lastIdx_d = (idx_q == (len_q - 8'd1));
    assign gapHit_d  = (gap_q == GAP_LAST);
    assign bufWrEn_d = (state_q == PAYLOAD) && receive_data_en;
    assign bufRdEn_d = (state_q == COMMIT);

    cmd_payload_buf #(
        .DEPTH (MAX_LEN),
        .WIDTH (16),
        .AW    (AW)
    ) u_buf (
        .clk_i    (usb_clk),
        .rst_i    (rst),
        .wrEn_i   (bufWrEn_d),
        .wrAddr_i (idx_q[AW-1:0]),
        .wrData_i (receive_data),
        .rdEn_i   (bufRdEn_d),
        .rdAddr_i (idx_q[AW-1:0]),
        .rdData_o (bufRdData)
    );

    // Decoder FSM; every output is a register so pulses line up with the buffered read data.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baseAddr_q <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            gap_q      <= '0;
            regWrEn_q  <= 1'b0;
            regAddr_q  <= '0;
            cmdOk_q    <= 1'b0;
            cmdErr_q   <= 1'b0;
            errCode_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            regWrEn_q <= 1'b0;
            cmdOk_q   <= 1'b0;
            cmdErr_q  <= 1'b0;
            overrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (receive_data_en && (receive_data == HDR_WORD)) begin
                        state_q <= CMD;
                        gap_q   <= '0;
                    end
                end

                CMD, PAYLOAD, CSUM: begin
                    if (!receive_data_en) begin
                        if (gapHit_d) begin
                            cmdErr_q  <= 1'b1;
                            errCode_q <= ERR_TMO;
                            gap_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            gap_q <= gap_q + GW'(1);
                        end
                    end else begin
                        gap_q <= '0;
                        case (state_q)
                            CMD: begin
                                baseAddr_q <= receive_data[15:8];
                                len_q      <= receive_data[7:0];
                                sum_q      <= receive_data;
                                idx_q      <= '0;
                                if (receive_data[7:0] > MAX_LEN_B) begin
                                    cmdErr_q  <= 1'b1;
                                    errCode_q <= ERR_LEN;
                                    state_q   <= IDLE;
                                end else if (receive_data[7:0] == 8'd0) begin
                                    state_q <= CSUM;
                                end else begin
                                    state_q <= PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                sum_q <= sumNext_d;
                                idx_q <= idx_q + 8'd1;
                                if (lastIdx_d) begin
                                    state_q <= CSUM;
                                end
                            end
                            CSUM: begin
                                if (receive_data != sum_q) begin
                                    cmdErr_q  <= 1'b1;
                                    errCode_q <= ERR_CSUM;
                                    state_q   <= IDLE;
                                end else if (len_q == 8'd0) begin
                                    cmdOk_q <= 1'b1;
                                    state_q <= IDLE;
                                end else begin
                                    idx_q   <= '0;
                                    state_q <= COMMIT;
                                end
                            end
                            default: begin
                                state_q <= IDLE;
                            end
                        endcase
                    end
                end

                // Each COMMIT cycle reads buf[idx]; the write strobe and address land with the data.
                COMMIT: begin
                    overrun_q <= receive_data_en;
                    regWrEn_q <= 1'b1;
                    regAddr_q <= wrapAddr(baseAddr_q, idx_q);
                    idx_q     <= idx_q + 8'd1;
                    if (lastIdx_d) begin
                        cmdOk_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign reg_wr_en = regWrEn_q;
    assign reg_addr  = regAddr_q;
    assign reg_wdata = bufRdData;
    assign cmd_ok    = cmdOk_q;
    assign cmd_err   = cmdErr_q;
    assign err_code  = errCode_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule
